// File: rtl/moore_seq_tx.sv
// rtl/moore_seq_tx.sv - Moore-FSM serial pattern transmitter, MSB-first, with repeat and gap
module moore_seq_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] eff_len;
    logic [IDX_W-1:0] first_idx;

    // Oversized lengths are clamped so the index never leaves the pattern register.
    always_comb begin
        eff_len   = (len > WIDTH_L) ? WIDTH_L : len;
        first_idx = IDX_W'(eff_len - LEN_W'(1));
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        last_d  = last_q;
        idx_d   = idx_q;
        rep_d   = rep_q;

        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    pat_d   = pattern;
                    last_d  = first_idx;
                    idx_d   = first_idx;
                    rep_d   = reps;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    if (rep_q != '0) begin
                        rep_d   = rep_q - REP_W'(1);
                        idx_d   = last_q;
                        state_d = GAP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            GAP:     state_d = SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in registers on the same edge.
    always_comb begin
        out_d   = (state_d == SHIFT) ? pat_d[idx_d] : 1'b0;
        valid_d = (state_d == SHIFT);
        busy_d  = (state_d == SHIFT) || (state_d == GAP);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_moore_seq_tx.sv
// tb/tb_moore_seq_tx.sv - self-checking bench for moore_seq_tx against a per-cycle frame model
module tb_moore_seq_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [2:0] reps;
    logic       out_s;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] hist = 4'b0;
    int         lb_hits = 0;

    always #5 clk = ~clk;

    moore_seq_tx #(.WIDTH(8), .LEN_W(4), .REP_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .reps      (reps),
        .out       (out_s),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    // Plain 1011 detector watching the raw serial line, gaps included.
    always @(posedge clk) begin
        hist <= {hist[2:0], out_s};
        if ({hist[2:0], out_s} == 4'b1011) lb_hits <= lb_hits + 1;
    end

    // Expected {out, out_valid, busy, done} for every cycle after the accept edge.
    function automatic void build_frame(logic [7:0] p, logic [3:0] l, logic [2:0] r);
        int n;
        n = (l > 4'd8) ? 8 : int'(l);
        if (n == 0) return;
        for (int k = 0; k <= int'(r); k++) begin
            for (int b = n - 1; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
            if (k < int'(r)) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endfunction

    task automatic send_and_check(string name, logic [7:0] p, logic [3:0] l, logic [2:0] r);
        exp_q.delete();
        build_frame(p, l, r);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        pattern = p; len = l; reps = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern = 8'($urandom); len = 4'($urandom); reps = 3'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({out_s, out_valid, busy, done} !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b required %b", name, i,
                         {out_s, out_valid, busy, done}, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({out_s, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required 0000", {out_s, out_valid, busy, done});
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_s, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: got %b required 0000", {out_s, out_valid, busy, done});
        end
    endtask

    task automatic test_single();
        send_and_check("single_1011", 8'h0B, 4'd4, 3'd0);
    endtask

    task automatic test_repeat();
        send_and_check("repeat_1011x3", 8'h0B, 4'd4, 3'd2);
    endtask

    task automatic test_boundaries();
        @(negedge clk);
        pattern = 8'hFF; len = 4'd0; reps = 3'd1; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL len0 cycle %0d: got busy=%b done=%b required 0 0", i, busy, done);
            end
        end
        start = 1'b0;
        send_and_check("clamp_len9", 8'hA5, 4'd9, 3'd0);
        send_and_check("len1", 8'h01, 4'd1, 3'd0);
        send_and_check("len1_reps", 8'h01, 4'd1, 3'd3);
    endtask

    task automatic test_ignore_busy();
        int dones = 0;
        exp_q.delete();
        build_frame(8'h0B, 4'd4, 3'd0);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        pattern = 8'h0B; len = 4'd4; reps = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (done === 1'b1) dones++;
            n_checks++;
            if ({out_s, out_valid, busy, done} !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ignore_busy cycle %0d: got %b required %b", i,
                         {out_s, out_valid, busy, done}, exp_q[i]);
            end
            if (i == 1) begin pattern = 8'hF0; len = 4'd8; reps = 3'd3; start = 1'b1; end
            if (i == 2) start = 1'b0;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignore_busy_dones: got %0d required 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        build_frame(8'h02, 4'd2, 3'd0);
        exp_q.push_back(4'b0000);
        build_frame(8'h02, 4'd2, 3'd0);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        pattern = 8'h02; len = 4'd2; reps = 3'd0; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({out_s, out_valid, busy, done} !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", i,
                         {out_s, out_valid, busy, done}, exp_q[i]);
            end
            if (i == 4) start = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        pattern = 8'h0B; len = 4'd4; reps = 3'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({out_s, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b required 0000", {out_s, out_valid, busy, done});
        end
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_s, out_valid, busy, done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL async_reset_idle cycle %0d: got %b required 0000", i,
                         {out_s, out_valid, busy, done});
            end
        end
        send_and_check("after_reset_1011", 8'h0B, 4'd4, 3'd0);
    endtask

    task automatic test_loopback();
        int base;
        repeat (5) @(negedge clk);
        base = lb_hits;
        send_and_check("loopback_stream", 8'h0B, 4'd4, 3'd1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (lb_hits - base != 2) begin
            n_fail++;
            $display("FAIL loopback_hits: got %0d required 2", lb_hits - base);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            send_and_check($sformatf("random_%0d", i), 8'($urandom),
                           4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pattern = 8'h00; len = 4'd0; reps = 3'd0;
        test_reset();
        test_single();
        test_repeat();
        test_boundaries();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        test_loopback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
